tlu_trigger_core: RTL

Parametrised single-clock trigger-decision core for the TLU master: N_IN beam-trigger channels and N_OUT DUT outputs. It forms a coincidence in AND, OR or majority mode under a leading-edge window. It gates the coincidence on DUT readiness and a veto, and counts trigger IDs, skipped triggers and lost records. Each accepted trigger's record is buffered in an internal FIFO and read out as 16-bit words. It sits in the SYS_CLK (40 MHz) domain between the tlu_ch_rx instances and the tlu_tx instances.

---
 rtl/tlu_trigger_core.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/tlu_trigger_core.sv
// tlu_trigger_core: trigger-decision core for the TLU master (SYS_CLK domain).
// Forms an AND / OR / majority coincidence of the enabled beam channels,
// applies a leading-edge window, gates the result on DUT readiness and veto,
// and buffers one record per accepted trigger for 16-bit word readout.
//
// Ports:
//   SYS_CLK, SYS_RST         clock, synchronous active-high reset
//   START                    restart run counters (ID, skip, lost, timestamp)
//   VALID, LE_REL            per-channel hit valid and relative leading edge
//   CONF_*                   channel enables, mode, majority, window, DUT enables
//   READY, VETO, TEST_PULSE  DUT readiness, level veto, forced trigger
//   TRIG, TRIG_ID, TRIG_LE   accepted-trigger pulse, current ID, MAX_LE[3:0]
//   TIME_STAMP               run timestamp (saturating)
//   SKIP_CNT, LOST_CNT       saturating skipped / dropped-record counters
//   FIFO_READ/EMPTY/DATA     record readout, one 16-bit word per read
module tlu_trigger_core #(
  parameter int N_IN      = 4,
  parameter int N_OUT     = 6,
  parameter int DEPTH     = 16,
  parameter int LE_OFFSET = 43
) (
  input  logic                SYS_CLK,
  input  logic                SYS_RST,
  input  logic                START,
  input  logic [N_IN-1:0]     VALID,
  input  logic [8*N_IN-1:0]   LE_REL,
  input  logic [N_IN-1:0]     CONF_EN_INPUT,
  input  logic [1:0]          CONF_MODE,
  input  logic [3:0]          CONF_MAJORITY,
  input  logic [4:0]          CONF_MAX_LE_DISTANCE,
  input  logic [N_OUT-1:0]    CONF_EN_OUTPUT,
  input  logic [N_OUT-1:0]    READY,
  input  logic                VETO,
  input  logic                TEST_PULSE,
  output logic                TRIG,
  output logic [31:0]         TRIG_ID,
  output logic [3:0]          TRIG_LE,
  output logic [63:0]         TIME_STAMP,
  output logic [7:0]          SKIP_CNT,
  output logic [7:0]          LOST_CNT,
  input  logic                FIFO_READ,
  output logic                FIFO_EMPTY,
  output logic [15:0]         FIFO_DATA
);

  localparam int NW  = (N_IN + 1) / 2;  // 16-bit words holding the LE bytes
  localparam int W   = 6 + NW;          // words per record
  localparam int LEW = NW * 16;
  localparam int RW  = W * 16;
  localparam int AW  = $clog2(DEPTH);
  localparam int WCW = $clog2(W);

  localparam logic [1:0] MODE_AND = 2'd0;
  localparam logic [1:0] MODE_OR  = 2'd1;
  localparam logic [1:0] MODE_MAJ = 2'd2;

  logic [N_IN-1:0] w_hit;
  logic [3:0]      w_n_en, w_n_hit;
  logic [7:0]      w_min_le, w_max_le, w_diff, w_le_i;
  logic [LEW-1:0]  w_le_rec;
  logic            w_mode_ok, w_window, w_cond, w_ok, w_pulse;

  logic            r_cond_q, r_cond_qq, r_trig;
  logic [31:0]     r_trig_id;
  logic [63:0]     r_ts;
  logic [7:0]      r_skip, r_lost;

  logic [RW-1:0]   r_mem [DEPTH];
  logic [AW:0]     r_wr, r_rd;
  logic [WCW-1:0]  r_word_cnt;
  logic [RW-1:0]   w_head;
  logic            w_fifo_empty, w_full, w_read, w_pop, w_push, w_lost;

  always_comb begin
    w_hit    = VALID & CONF_EN_INPUT;
    w_n_en   = '0;
    w_n_hit  = '0;
    w_min_le = '1;
    w_max_le = '0;
    w_le_i   = '0;
    w_le_rec = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      w_le_i  = LE_REL[8*i +: 8];
      w_n_en  = w_n_en + 4'(CONF_EN_INPUT[i]);
      w_n_hit = w_n_hit + 4'(w_hit[i]);
      if (w_hit[i]) begin
        if (w_le_i < w_min_le) w_min_le = w_le_i;
        if (w_le_i > w_max_le) w_max_le = w_le_i;
      end
      if (CONF_EN_INPUT[i]) w_le_rec[8*i +: 8] = w_le_i + 8'(LE_OFFSET);
    end
    // With no hits the extremes are meaningless; pin both to zero.
    if (w_hit == '0) w_min_le = '0;
    w_diff   = w_max_le - w_min_le;
    w_window = w_diff < {3'b000, CONF_MAX_LE_DISTANCE};
    case (CONF_MODE)
      MODE_AND: w_mode_ok = (w_hit == CONF_EN_INPUT) && (w_n_en != '0);
      MODE_OR:  w_mode_ok = (w_hit != '0);
      MODE_MAJ: w_mode_ok = (w_n_hit >= CONF_MAJORITY) && (CONF_MAJORITY != '0);
      default:  w_mode_ok = 1'b0;
    endcase
    w_cond  = (w_mode_ok & w_window) | TEST_PULSE;
    w_ok    = (&(READY | ~CONF_EN_OUTPUT)) & ~VETO;
    w_pulse = r_cond_q & ~r_cond_qq;
  end

  // Record FIFO: pointers carry one extra wrap bit to separate full from empty.
  always_comb begin
    w_fifo_empty = (r_wr == r_rd);
    w_full       = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    FIFO_EMPTY   = (r_word_cnt == '0) && w_fifo_empty;
    w_read       = FIFO_READ & ~FIFO_EMPTY;
    w_pop        = w_read && (r_word_cnt == WCW'(W - 1));
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    w_push       = r_trig & (~w_full | w_pop);
    w_lost       = r_trig & w_full & ~w_pop;
    w_head       = r_mem[r_rd[AW-1:0]];
    FIFO_DATA    = w_fifo_empty ? '0 : w_head[{r_word_cnt, 4'b0000} +: 16];
  end

  always_ff @(posedge SYS_CLK) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= {w_le_rec, r_ts, r_trig_id};
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      r_cond_q   <= 1'b0;
      r_cond_qq  <= 1'b0;
      r_trig     <= 1'b0;
      r_trig_id  <= '0;
      r_ts       <= 64'd1;
      r_skip     <= '0;
      r_lost     <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_word_cnt <= '0;
    end else begin
      r_cond_q  <= w_cond;
      r_cond_qq <= r_cond_q;
      r_trig    <= w_pulse & w_ok & ~START;
      if (START) begin
        r_trig_id <= '0;
        r_skip    <= '0;
        r_lost    <= '0;
        r_ts      <= 64'd1;
      end else begin
        if (r_trig) r_trig_id <= r_trig_id + 32'd1;
        if (w_pulse && !w_ok && r_skip != '1) r_skip <= r_skip + 8'd1;
        if (w_lost && r_lost != '1) r_lost <= r_lost + 8'd1;
        if (r_ts != '1) r_ts <= r_ts + 64'd1;
      end
      if (w_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_pop)  r_rd <= r_rd + (AW+1)'(1);
      if (w_read) r_word_cnt <= w_pop ? '0 : r_word_cnt + WCW'(1);
    end
  end

  assign TRIG       = r_trig;
  assign TRIG_ID    = r_trig_id;
  assign TRIG_LE    = w_max_le[3:0];
  assign TIME_STAMP = r_ts;
  assign SKIP_CNT   = r_skip;
  assign LOST_CNT   = r_lost;

endmodule
